canvas_painter: RTL and testbench
=================================

CANVAS_PAINTER -- requirements
Module: canvas_painter

Interface
REQ-001 Parameter COORD_W, default 3: coordinate width; canvas is 2^COORD_W x 2^COORD_W pixels (8x8 at default).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 colour_in  input  3  brush colour {R,G,B} from the colour mixer.
REQ-005 paint_enable  input  1  1 = modify pixel, 0 = move only (no write).
REQ-006 cursor_x  input  COORD_W  column of stroke target.
REQ-007 cursor_y  input  COORD_W  row of stroke target.
REQ-008 stroke_req  input  1  level request to paint the pixel at cursor.
REQ-009 clear_req  input  1  level request to fill the whole canvas with black (000).
REQ-010 op_ack  output  1  one-cycle pulse when a stroke or clear completes.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 rd_x  input  COORD_W  display read column.
REQ-013 rd_y  input  COORD_W  display read row.
REQ-014 rd_pixel  output  3  registered colour of pixel (rd_x, rd_y).

Function
REQ-015 Storage SHALL be 2^(2*COORD_W) entries x 3 bits, addressed as {y, x}.
REQ-016 FSM states SHALL be IDLE, PAINT, CLEAR, DONE.
REQ-017 IDLE: clear_req=1 -> CLEAR, clear counter set to 0; clear_req takes priority over a simultaneous stroke_req.
REQ-018 IDLE: stroke_req=1 and clear_req=0 -> PAINT.
REQ-019 Transition into PAINT SHALL latch cursor_x, cursor_y, colour_in and paint_enable at the same edge; later input changes do not affect the stroke.
REQ-020 PAINT: if the latched paint_enable=1, the latched colour is written to the latched address at the next edge; if 0, no storage changes. Either way -> DONE.
REQ-021 CLEAR: each cycle writes 000 to the entry at the counter and increments it. After the last entry (all ones), the state goes -> DONE; a clear takes exactly 2^(2*COORD_W) write cycles.
REQ-022 DONE: op_ack=1 for exactly this cycle, then -> IDLE unconditionally.
REQ-023 busy SHALL be 1 in PAINT, CLEAR and DONE, and 0 in IDLE.
REQ-024 stroke_req and clear_req asserted while busy=1 SHALL be ignored, not queued. A request still high on return to IDLE starts a new operation.
REQ-025 Stroke latency: request sampled at edge k; storage written at edge k+1; op_ack high in the cycle following edge k+1.
REQ-026 rd_pixel SHALL update every edge from (rd_x, rd_y), with 1-cycle latency, independent of FSM state.
REQ-027 Read/write to the same entry at the same edge: rd_pixel SHALL return the pre-write value; the new value is visible one edge later.
REQ-028 Eraser strokes arrive as colour_in=000 with paint_enable=1 and SHALL write 000 like any colour.

Reset
REQ-029 rst=1 at an edge SHALL set: state IDLE, all storage entries 000, rd_pixel 000, op_ack 0, busy 0, clear counter 0, latched stroke registers 0.
REQ-030 rst asserted mid-PAINT or mid-CLEAR SHALL abort the operation with no op_ack; reset values take precedence over any pending write.
REQ-031 Requests held high during reset SHALL be acted on only at the first edge with rst=0.

Verification
REQ-032 Stroke: cursor (3,5), colour_in=110, paint_enable=1, stroke_req pulsed 1 cycle. Required: op_ack 2 cycles later; reading rd_x=3, rd_y=5 returns 110; all other pixels stay 000.
REQ-033 Move-only: cursor (2,2), paint_enable=0, colour 101, stroke_req. Required: op_ack after 2 cycles; pixel (2,2) remains at its prior value.
REQ-034 Clear: paint (0,0)=111 and (7,7)=001, then clear_req for 1 cycle. Required: busy high for 65 cycles (64 CLEAR + DONE), a single op_ack, and all 64 pixels read 000.
REQ-035 Priority/ignore: stroke_req and clear_req rise together, then stroke_req is pulsed again during CLEAR. Required: only the clear executes, one op_ack, no stroke write.
REQ-036 Reset mid-clear: paint several pixels, start a clear, assert rst at cycle 10. Required: no op_ack, busy=0, all pixels 000, rd_pixel=000 on the next edge.
REQ-037 Read collision: rd at (1,1) while a stroke writes 011 to (1,1). Required: rd_pixel shows the old value at the write edge and 011 one cycle later.

Source files
------------

// File: rtl/canvas_painter_if.sv
// Command handshake between the brush controller and canvas_painter.
// Requests are levels; op_ack pulses once per completed operation.
interface canvas_painter_if #(
  parameter int COORD_W = 3
);
  logic [2:0]         colour_in;
  logic               paint_enable;
  logic [COORD_W-1:0] cursor_x;
  logic [COORD_W-1:0] cursor_y;
  logic               stroke_req;
  logic               clear_req;
  logic               op_ack;
  logic               busy;

  modport master (
    output colour_in,
    output paint_enable,
    output cursor_x,
    output cursor_y,
    output stroke_req,
    output clear_req,
    input  op_ack,
    input  busy
  );

  modport slave (
    input  colour_in,
    input  paint_enable,
    input  cursor_x,
    input  cursor_y,
    input  stroke_req,
    input  clear_req,
    output op_ack,
    output busy
  );
endinterface

// File: rtl/canvas_painter.sv
// Pixel canvas: single-pixel strokes, full clears, registered read port.
// Storage is flop-based so reset can blank every entry in one edge.
module canvas_painter #(
  parameter int COORD_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  canvas_painter_if.slave    cmd,
  input  logic [COORD_W-1:0] rd_x,
  input  logic [COORD_W-1:0] rd_y,
  output logic [2:0]         rd_pixel
);

  localparam int AW    = 2 * COORD_W;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE,
    PAINT,
    CLEAR,
    DONE
  } state_t;

  state_t          state;
  logic [AW-1:0]   clr_cnt;
  logic [AW-1:0]   lat_addr;
  logic [2:0]      lat_col;
  logic            lat_en;
  logic            op_ack_q;
  logic            busy_q;

  logic [2:0]      mem [DEPTH];

  logic            we;
  logic [AW-1:0]   waddr;
  logic [2:0]      wdata;

  assign cmd.op_ack = op_ack_q;
  assign cmd.busy   = busy_q;

  always_comb begin
    we    = 1'b0;
    waddr = lat_addr;
    wdata = lat_col;
    unique case (state)
      PAINT: we = lat_en;
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_cnt;
        wdata = 3'b000;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      lat_addr <= '0;
      lat_col  <= '0;
      lat_en   <= 1'b0;
      op_ack_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      op_ack_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd.clear_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy_q  <= 1'b1;
          end else if (cmd.stroke_req) begin
            state    <= PAINT;
            lat_addr <= {cmd.cursor_y, cmd.cursor_x};
            lat_col  <= cmd.colour_in;
            lat_en   <= cmd.paint_enable;
            busy_q   <= 1'b1;
          end
        end
        PAINT: begin
          state    <= DONE;
          op_ack_q <= 1'b1;
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            state    <= DONE;
            op_ack_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Read samples the pre-write value; a same-edge write shows next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 3'b000;
      end
      rd_pixel <= 3'b000;
    end else begin
      rd_pixel <= mem[{rd_y, rd_x}];
      if (we) begin
        mem[waddr] <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_canvas_painter.sv
// Self-checking bench for canvas_painter: vector table, corner sequences,
// and random traffic against an operation-level reference model.
module tb_canvas_painter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rd_x;
  logic [2:0] rd_y;
  logic [2:0] rd_pixel;

  canvas_painter_if #(.COORD_W(3)) cif();

  canvas_painter #(.COORD_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cif.slave),
    .rd_x     (rd_x),
    .rd_y     (rd_y),
    .rd_pixel (rd_pixel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: memory image plus remaining busy cycles of the op.
  bit [2:0] m [64];
  int       rem = 0;
  bit       m_clr;
  bit [5:0] m_addr;
  bit [2:0] m_col;
  bit       m_en;
  bit [2:0] e_rd;
  bit       e_busy;
  bit       e_ack;
  int       ack_cnt;
  int       busy_cnt;

  typedef struct {
    bit       s;
    bit       pe;
    bit [2:0] col;
    bit [2:0] x;
    bit [2:0] y;
    bit [2:0] rx;
    bit [2:0] ry;
    bit       eb;
    bit       ea;
    bit [2:0] er;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      rem = 0;
      foreach (m[i]) m[i] = 3'b000;
      e_rd = 3'b000;
    end else begin
      e_rd = m[{rd_y, rd_x}];
      if (rem == 0) begin
        if (cif.clear_req) begin
          rem   = 65;
          m_clr = 1'b1;
        end else if (cif.stroke_req) begin
          rem    = 2;
          m_clr  = 1'b0;
          m_addr = {cif.cursor_y, cif.cursor_x};
          m_col  = cif.colour_in;
          m_en   = cif.paint_enable;
        end
      end else begin
        if (m_clr && rem >= 2) m[65 - rem] = 3'b000;
        if (!m_clr && rem == 2 && m_en) m[m_addr] = m_col;
        rem--;
      end
    end
    e_busy = (rem != 0);
    e_ack  = (rem == 1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("busy", int'(cif.busy), int'(e_busy));
    chk("op_ack", int'(cif.op_ack), int'(e_ack));
    chk("rd_pixel", int'(rd_pixel), int'(e_rd));
    if (cif.op_ack) ack_cnt++;
    if (cif.busy) busy_cnt++;
  endtask

  task automatic idle_inputs();
    cif.stroke_req   = 1'b0;
    cif.clear_req    = 1'b0;
    cif.paint_enable = 1'b0;
    cif.colour_in    = 3'b000;
    cif.cursor_x     = 3'd0;
    cif.cursor_y     = 3'd0;
  endtask

  task automatic paint(input logic [2:0] x, input logic [2:0] y,
                       input logic [2:0] col, input bit pe);
    cif.stroke_req   = 1'b1;
    cif.cursor_x     = x;
    cif.cursor_y     = y;
    cif.colour_in    = col;
    cif.paint_enable = pe;
    tick();
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic read_all(input bit want_zero);
    for (int a = 0; a < 64; a++) begin
      rd_x = a[2:0];
      rd_y = a[5:3];
      tick();
      if (want_zero) chk("pix_zero", int'(rd_pixel), 0);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (cif.busy && n < 200) begin
      tick();
      n++;
    end
    chk(name, int'(n < 200), 1);
  endtask

  initial begin
    rst  = 1'b1;
    rd_x = 3'd0;
    rd_y = 3'd0;
    idle_inputs();
    tick();
    tick();
    chk("rst_busy", int'(cif.busy), 0);
    chk("rst_ack", int'(cif.op_ack), 0);
    chk("rst_rd", int'(rd_pixel), 0);
    rst = 1'b0;

    tbl[0]  = '{1, 1, 3'd6, 3'd3, 3'd5, 3'd3, 3'd5, 1, 0, 3'd0};
    tbl[1]  = '{0, 1, 3'd6, 3'd3, 3'd5, 3'd3, 3'd5, 1, 1, 3'd0};
    tbl[2]  = '{0, 0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd5, 0, 0, 3'd6};
    tbl[3]  = '{0, 0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 0, 0, 3'd0};
    tbl[4]  = '{1, 0, 3'd5, 3'd2, 3'd2, 3'd2, 3'd2, 1, 0, 3'd0};
    tbl[5]  = '{0, 1, 3'd7, 3'd2, 3'd2, 3'd2, 3'd2, 1, 1, 3'd0};
    tbl[6]  = '{0, 0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 0, 0, 3'd0};
    tbl[7]  = '{1, 1, 3'd0, 3'd3, 3'd5, 3'd3, 3'd5, 1, 0, 3'd6};
    tbl[8]  = '{0, 0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd5, 1, 1, 3'd6};
    tbl[9]  = '{0, 0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd5, 0, 0, 3'd0};
    tbl[10] = '{1, 1, 3'd3, 3'd1, 3'd1, 3'd0, 3'd0, 1, 0, 3'd0};
    tbl[11] = '{0, 1, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 1, 1, 3'd0};
    tbl[12] = '{0, 0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 0, 0, 3'd3};
    tbl[13] = '{0, 0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 0, 0, 3'd0};

    for (int i = 0; i < 14; i++) begin
      cif.stroke_req   = tbl[i].s;
      cif.paint_enable = tbl[i].pe;
      cif.colour_in    = tbl[i].col;
      cif.cursor_x     = tbl[i].x;
      cif.cursor_y     = tbl[i].y;
      rd_x             = tbl[i].rx;
      rd_y             = tbl[i].ry;
      tick();
      chk($sformatf("vec%0d_busy", i), int'(cif.busy), int'(tbl[i].eb));
      chk($sformatf("vec%0d_ack", i), int'(cif.op_ack), int'(tbl[i].ea));
      chk($sformatf("vec%0d_rd", i), int'(rd_pixel), int'(tbl[i].er));
    end
    idle_inputs();
    read_all(1'b0);

    // Clear after painting the two corners.
    paint(3'd0, 3'd0, 3'd7, 1'b1);
    paint(3'd7, 3'd7, 3'd1, 1'b1);
    ack_cnt  = 0;
    busy_cnt = 0;
    cif.clear_req = 1'b1;
    tick();
    cif.clear_req = 1'b0;
    wait_idle("clr_timeout");
    chk("clr_busy_cycles", busy_cnt, 65);
    chk("clr_acks", ack_cnt, 1);
    read_all(1'b1);

    // Simultaneous requests, then a stroke pulse during the clear.
    ack_cnt = 0;
    cif.stroke_req   = 1'b1;
    cif.clear_req    = 1'b1;
    cif.cursor_x     = 3'd6;
    cif.cursor_y     = 3'd6;
    cif.colour_in    = 3'd7;
    cif.paint_enable = 1'b1;
    tick();
    idle_inputs();
    repeat (8) tick();
    cif.stroke_req   = 1'b1;
    cif.cursor_x     = 3'd4;
    cif.cursor_y     = 3'd4;
    cif.colour_in    = 3'd5;
    cif.paint_enable = 1'b1;
    tick();
    idle_inputs();
    wait_idle("prio_timeout");
    chk("prio_acks", ack_cnt, 1);
    tick();
    chk("prio_no_queue", int'(cif.busy), 0);
    read_all(1'b1);

    // Reset in the middle of a clear.
    paint(3'd1, 3'd2, 3'd3, 1'b1);
    paint(3'd5, 3'd5, 3'd4, 1'b1);
    paint(3'd7, 3'd0, 3'd2, 1'b1);
    ack_cnt = 0;
    cif.clear_req = 1'b1;
    tick();
    cif.clear_req = 1'b0;
    repeat (9) tick();
    rst  = 1'b1;
    rd_x = 3'd5;
    rd_y = 3'd5;
    tick();
    chk("rstclr_busy", int'(cif.busy), 0);
    chk("rstclr_ack", int'(cif.op_ack), 0);
    chk("rstclr_rd", int'(rd_pixel), 0);
    rst = 1'b0;
    tick();
    chk("rstclr_rd_next", int'(rd_pixel), 0);
    chk("rstclr_no_ack", ack_cnt, 0);
    read_all(1'b1);

    // Request held through reset starts at the first released edge.
    rst              = 1'b1;
    cif.stroke_req   = 1'b1;
    cif.cursor_x     = 3'd2;
    cif.cursor_y     = 3'd3;
    cif.colour_in    = 3'd6;
    cif.paint_enable = 1'b1;
    tick();
    chk("held_rst_busy", int'(cif.busy), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("held_start_busy", int'(cif.busy), 1);
    idle_inputs();
    tick();
    tick();
    rd_x = 3'd2;
    rd_y = 3'd3;
    tick();
    chk("held_pixel", int'(rd_pixel), 6);

    // Read/write collision on the same entry.
    paint(3'd1, 3'd1, 3'd5, 1'b1);
    rd_x             = 3'd1;
    rd_y             = 3'd1;
    cif.stroke_req   = 1'b1;
    cif.cursor_x     = 3'd1;
    cif.cursor_y     = 3'd1;
    cif.colour_in    = 3'd3;
    cif.paint_enable = 1'b1;
    tick();
    idle_inputs();
    tick();
    chk("coll_old", int'(rd_pixel), 5);
    tick();
    chk("coll_new", int'(rd_pixel), 3);

    // Random traffic against the model.
    repeat (3000) begin
      rst              = ($urandom % 300) == 0;
      cif.stroke_req   = ($urandom % 3) == 0;
      cif.clear_req    = ($urandom % 60) == 0;
      cif.cursor_x     = 3'($urandom);
      cif.cursor_y     = 3'($urandom);
      cif.colour_in    = 3'($urandom);
      cif.paint_enable = ($urandom % 4) != 0;
      rd_x             = 3'($urandom);
      rd_y             = 3'($urandom);
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    wait_idle("rand_timeout");
    read_all(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
